svm_knn_acc_classifier: RTL and testbench

SVM_KNN_ACC_CLASSIFIER -- requirements
Module: svm_knn_acc_classifier

---
 rtl/svm_knn_acc_pkg.sv | 30 +++
 rtl/svm_knn_acc_dp.sv | 61 ++++++
 rtl/svm_knn_acc_classifier.sv | 147 ++++++++++++++
 tb/tb_svm_knn_acc_classifier.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/svm_knn_acc_pkg.sv
// Shared types, encodings and widths for the SVM/KNN accelerator.
package svm_knn_acc_pkg;

  localparam int unsigned ACC_W  = 40;
  localparam int unsigned DIST_W = 24;
  localparam int unsigned FEAT_W = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned DIFF_W = FEAT_W + 1;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_SVM  = 2'b01;
  localparam logic [1:0] MODE_KNN  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ACCEPT,
    BIAS,
    DONE
  } state_t;

  // Coefficient word: SVM weight/bias or KNN centroid 0 in c0, KNN centroid 1 in c1.
  typedef struct packed {
    logic signed [FEAT_W-1:0] c1;
    logic signed [FEAT_W-1:0] c0;
  } coef_t;

endpackage

// File: rtl/svm_knn_acc_dp.sv
// Datapath: SVM multiply-accumulate, KNN abs-difference distances, score/label.
module svm_knn_acc_dp
  import svm_knn_acc_pkg::*;
(
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              clr,
  input  logic              acc_en,
  input  logic              mode_svm,
  input  logic [FEAT_W-1:0] feat_data,
  input  logic [WORD_W-1:0] w_data,
  output logic [ACC_W-1:0]  score_c,
  output logic              label_c
);

  coef_t                     coef;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [DIFF_W-1:0]  diff0_c;
  logic signed [DIFF_W-1:0]  diff1_c;
  logic [DIFF_W-1:0]         abs0_c;
  logic [DIFF_W-1:0]         abs1_c;
  logic [ACC_W-1:0]          acc;
  logic [DIST_W-1:0]         d0;
  logic [DIST_W-1:0]         d1;
  logic signed [DIST_W:0]    knn_diff_c;
  logic [ACC_W-1:0]          svm_score_c;

  assign coef    = coef_t'(w_data);
  assign prod_c  = PROD_W'($signed(feat_data)) * PROD_W'(coef.c0);
  assign diff0_c = DIFF_W'($signed(feat_data)) - DIFF_W'(coef.c0);
  assign diff1_c = DIFF_W'($signed(feat_data)) - DIFF_W'(coef.c1);
  assign abs0_c  = diff0_c[DIFF_W-1] ? DIFF_W'(-diff0_c) : DIFF_W'(diff0_c);
  assign abs1_c  = diff1_c[DIFF_W-1] ? DIFF_W'(-diff1_c) : DIFF_W'(diff1_c);

  // Accumulators: cleared on start, updated once per accepted feature.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      acc <= '0;
      d0  <= '0;
      d1  <= '0;
    end else if (clr) begin
      acc <= '0;
      d0  <= '0;
      d1  <= '0;
    end else if (acc_en) begin
      if (mode_svm) begin
        acc <= acc + {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
      end else begin
        d0 <= d0 + DIST_W'(abs0_c);
        d1 <= d1 + DIST_W'(abs1_c);
      end
    end
  end

  // Final score: bias word is on w_data while the FSM sits in DONE.
  assign svm_score_c = acc + {{(ACC_W-FEAT_W){coef.c0[FEAT_W-1]}}, coef.c0};
  assign knn_diff_c  = $signed({1'b0, d0}) - $signed({1'b0, d1});
  assign score_c     = mode_svm ? svm_score_c : ACC_W'(knn_diff_c);
  assign label_c     = mode_svm ? ~svm_score_c[ACC_W-1] : (d1 < d0);

endmodule

// File: rtl/svm_knn_acc_classifier.sv
// SVM / KNN stress classifier: feature-stream FSM around the accumulator datapath.
module svm_knn_acc_classifier
  import svm_knn_acc_pkg::*;
#(
  parameter int unsigned NUM_FEAT = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [1:0]        reg_start,
  input  logic              logic_op,
  input  logic              feat_valid,
  input  logic [FEAT_W-1:0] feat_data,
  output logic              feat_ready,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [WORD_W-1:0] w_data,
  output logic              busy,
  output logic              done,
  output logic              result_label,
  output logic [ACC_W-1:0]  result_score
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_FEAT - 1);
  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(NUM_FEAT);

  state_t             state;
  state_t             state_n;
  logic [1:0]         reg_start_d;
  logic               mode_svm;
  logic               mode_svm_n;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  idx_n;
  logic [ADDR_W-1:0]  w_addr_n;
  logic               busy_n;
  logic               feat_ready_n;
  logic               start_c;
  logic               abort_c;
  logic               clr_c;
  logic               acc_en_c;
  logic               load_res_c;
  logic [ACC_W-1:0]   score_c;
  logic               label_c;

  // Start needs a fresh 00 -> SVM/KNN edge; 00 while running aborts.
  assign start_c = ((reg_start == MODE_SVM) || (reg_start == MODE_KNN)) &&
                   (reg_start_d == MODE_IDLE);
  assign abort_c = (reg_start == MODE_IDLE);

  // State and registered control outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      reg_start_d <= MODE_IDLE;
      mode_svm    <= 1'b0;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      feat_ready  <= 1'b0;
      w_addr      <= '0;
    end else begin
      state       <= state_n;
      reg_start_d <= reg_start;
      mode_svm    <= mode_svm_n;
      idx         <= idx_n;
      busy        <= busy_n;
      done        <= load_res_c;
      feat_ready  <= feat_ready_n;
      w_addr      <= w_addr_n;
    end
  end

  // Next state, datapath strobes and next values of the registered outputs.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    mode_svm_n = mode_svm;
    clr_c      = 1'b0;
    acc_en_c   = 1'b0;
    load_res_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_c) begin
          state_n    = FETCH;
          idx_n      = '0;
          mode_svm_n = (reg_start == MODE_SVM);
          clr_c      = 1'b1;
        end
      end
      FETCH: begin
        state_n = abort_c ? IDLE : ACCEPT;
      end
      ACCEPT: begin
        if (abort_c) begin
          state_n = IDLE;
        end else if (feat_valid && feat_ready) begin
          acc_en_c = 1'b1;
          if (idx == LAST_IDX) begin
            state_n = mode_svm ? BIAS : DONE;
          end else begin
            idx_n   = idx + ADDR_W'(1);
            state_n = FETCH;
          end
        end
      end
      BIAS: begin
        state_n = abort_c ? IDLE : DONE;
      end
      DONE: begin
        state_n    = IDLE;
        load_res_c = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    busy_n       = (state_n != IDLE);
    feat_ready_n = (state_n == ACCEPT);
    w_addr_n     = '0;
    if ((state_n == FETCH) || (state_n == ACCEPT)) begin
      w_addr_n = idx_n;
    end else if (state_n == BIAS) begin
      w_addr_n = BIAS_ADDR;
    end
  end

  // Result registers: loaded only on completion, held otherwise.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      result_label <= 1'b0;
      result_score <= '0;
    end else if (load_res_c) begin
      result_label <= label_c ^ logic_op;
      result_score <= score_c;
    end
  end

  svm_knn_acc_dp u_dp (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .clr       (clr_c),
    .acc_en    (acc_en_c),
    .mode_svm  (mode_svm),
    .feat_data (feat_data),
    .w_data    (w_data),
    .score_c   (score_c),
    .label_c   (label_c)
  );

endmodule

// File: tb/tb_svm_knn_acc_classifier.sv
// Directed bench for svm_knn_acc_classifier with a 1-cycle coefficient memory model.
module tb_svm_knn_acc_classifier;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  reg_start;
  logic        logic_op;
  logic        feat_valid;
  logic [15:0] feat_data;
  logic        feat_ready;
  logic [6:0]  w_addr;
  logic [31:0] w_data;
  logic        busy;
  logic        done;
  logic        result_label;
  logic [39:0] result_score;

  logic [31:0] mem [0:127];

  int total;
  int bad;

  svm_knn_acc_classifier #(.NUM_FEAT(8)) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .reg_start    (reg_start),
    .logic_op     (logic_op),
    .feat_valid   (feat_valid),
    .feat_data    (feat_data),
    .feat_ready   (feat_ready),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .busy         (busy),
    .done         (done),
    .result_label (result_label),
    .result_score (result_score)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Synchronous coefficient memory: data one cycle after address.
  always @(posedge PCLK) w_data <= mem[w_addr];

  typedef struct {
    logic [1:0]  mode;
    logic        lop;
    int          fbase;
    int          fstep;
    int          c0;
    int          c1;
    int          bias;
    logic [39:0] score;
    logic        label;
    int          edges;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] m, input logic l, input int fb, input int fs,
                              input int c0, input int c1, input int b, input longint s,
                              input logic lab, input int e);
    vec_t v;
    v.mode = m; v.lop = l; v.fbase = fb; v.fstep = fs; v.c0 = c0; v.c1 = c1;
    v.bias = b; v.score = 40'(s); v.label = lab; v.edges = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one sample with feat_valid held (or every 3rd cycle when toggle);
  // optional abort or mode flip once abort_k / switch_k features have been sent.
  task automatic run(input vec_t v, input bit toggle, input int abort_k, input int switch_k,
                     output int edges, output bit got_done, output int ready_err);
    int k;
    bit hs;
    bit prev_hs;
    bit aborted;
    bit abort_edge;
    for (int i = 0; i < 8; i++) mem[i] = {16'(v.c1), 16'(v.c0)};
    mem[8] = {16'h0000, 16'(v.bias)};
    logic_op = v.lop;
    k = 0; edges = 0; got_done = 1'b0; ready_err = 0;
    prev_hs = 1'b0; aborted = 1'b0; abort_edge = 1'b0;
    @(negedge PCLK);
    reg_start = v.mode;
    for (int c = 0; c < 120 && !got_done; c++) begin
      if (abort_k >= 0 && k == abort_k && !aborted) begin
        reg_start = 2'b00;
        aborted = 1'b1;
        abort_edge = 1'b1;
      end
      if (switch_k >= 0 && k >= switch_k) reg_start = (v.mode == 2'b01) ? 2'b10 : 2'b01;
      feat_valid = toggle ? (c % 3 == 2) : 1'b1;
      feat_data = 16'(v.fbase + k * v.fstep);
      if (prev_hs && feat_ready) ready_err++;
      hs = feat_valid && feat_ready;
      @(posedge PCLK);
      edges++;
      #1;
      if (hs) k++;
      if (done) got_done = 1'b1;
      if (abort_edge) begin
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort feat_ready", 64'(feat_ready), 64'd0);
        abort_edge = 1'b0;
      end
      prev_hs = hs;
      @(negedge PCLK);
    end
    feat_valid = 1'b0;
    reg_start = 2'b00;
  endtask

  vec_t vecs [10];

  initial begin
    int  edges;
    bit  got_done;
    int  rerr;
    bit  seen;

    total = 0; bad = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    reg_start = 2'b00; logic_op = 1'b0; feat_valid = 1'b0; feat_data = 16'h0;

    vecs[0] = mk(2'b01, 1'b0, 1, 1, 1, 0, -5, 31, 1'b1, 19);
    vecs[1] = mk(2'b10, 1'b0, 90, 0, 0, 100, 0, 640, 1'b1, 18);
    vecs[2] = mk(2'b10, 1'b1, 90, 0, 0, 100, 0, 640, 1'b0, 18);
    vecs[3] = mk(2'b01, 1'b0, 1, 1, -2, 0, 10, -62, 1'b0, 19);
    vecs[4] = mk(2'b01, 1'b0, 1, 0, 1, 0, -8, 0, 1'b1, 19);
    vecs[5] = mk(2'b01, 1'b1, 1, 0, 1, 0, -8, 0, 1'b0, 19);
    vecs[6] = mk(2'b10, 1'b0, 20, 0, 10, 30, 0, 0, 1'b0, 18);
    vecs[7] = mk(2'b01, 1'b0, -32768, 0, -32768, 0, 0, 64'd8589934592, 1'b1, 19);
    vecs[8] = mk(2'b10, 1'b0, -32768, 0, 32767, -32768, 0, 524280, 1'b1, 18);
    vecs[9] = mk(2'b10, 1'b0, 90, 0, 100, 0, 0, -640, 1'b0, 18);

    // Asynchronous reset values.
    PRESETn = 1'b1;
    #3 PRESETn = 1'b0;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst feat_ready", 64'(feat_ready), 64'd0);
    chk("rst w_addr", 64'(w_addr), 64'd0);
    chk("rst label", 64'(result_label), 64'd0);
    chk("rst score", {24'd0, result_score}, 64'd0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    // Table of complete samples.
    for (int i = 0; i < 10; i++) begin
      run(vecs[i], 1'b0, -1, -1, edges, got_done, rerr);
      chk($sformatf("v%0d done", i), 64'(got_done), 64'd1);
      chk($sformatf("v%0d edges", i), 64'(edges), 64'(vecs[i].edges));
      chk($sformatf("v%0d score", i), {24'd0, result_score}, {24'd0, vecs[i].score});
      chk($sformatf("v%0d label", i), 64'(result_label), 64'(vecs[i].label));
      chk($sformatf("v%0d ready", i), 64'(rerr), 64'd0);
      @(posedge PCLK); #1;
      chk($sformatf("v%0d done pulse", i), 64'(done), 64'd0);
      chk($sformatf("v%0d idle busy", i), 64'(busy), 64'd0);
      chk($sformatf("v%0d idle w_addr", i), 64'(w_addr), 64'd0);
      @(negedge PCLK);
    end

    // Abort after 3 features: no done, prior KNN result (-640, 0) held.
    run(vecs[0], 1'b0, 3, -1, edges, got_done, rerr);
    chk("abort no done", 64'(got_done), 64'd0);
    chk("abort held score", {24'd0, result_score}, {24'd0, vecs[9].score});
    chk("abort held label", 64'(result_label), 64'd0);

    // 00 -> 11 -> 10 must not start.
    seen = 1'b0;
    @(negedge PCLK); reg_start = 2'b11;
    repeat (2) begin @(posedge PCLK); #1; if (busy) seen = 1'b1; end
    @(negedge PCLK); reg_start = 2'b10;
    repeat (4) begin @(posedge PCLK); #1; if (busy) seen = 1'b1; end
    chk("no start via 11", 64'(seen), 64'd0);
    @(negedge PCLK); reg_start = 2'b00;
    @(negedge PCLK);

    // 01 -> 10 while busy: latched SVM completes, no restart afterwards.
    run(vecs[0], 1'b0, -1, 2, edges, got_done, rerr);
    reg_start = 2'b10;
    chk("switch done", 64'(got_done), 64'd1);
    chk("switch edges", 64'(edges), 64'd19);
    chk("switch score", {24'd0, result_score}, 64'd31);
    chk("switch label", 64'(result_label), 64'd1);
    seen = 1'b0;
    repeat (5) begin @(posedge PCLK); #1; if (busy) seen = 1'b1; end
    chk("switch no restart", 64'(seen), 64'd0);
    @(negedge PCLK); reg_start = 2'b00;
    @(negedge PCLK);

    // Throttled stream gives the same result as back-to-back.
    run(vecs[3], 1'b1, -1, -1, edges, got_done, rerr);
    chk("toggle done", 64'(got_done), 64'd1);
    chk("toggle score", {24'd0, result_score}, {24'd0, vecs[3].score});
    chk("toggle label", 64'(result_label), 64'd0);
    chk("toggle ready", 64'(rerr), 64'd0);

    // Reset pulse mid-run.
    @(negedge PCLK);
    for (int i = 0; i < 8; i++) mem[i] = {16'h0, 16'd1};
    reg_start = 2'b01; feat_valid = 1'b1; feat_data = 16'd1;
    repeat (6) @(posedge PCLK);
    #2 PRESETn = 1'b0; reg_start = 2'b00; feat_valid = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst feat_ready", 64'(feat_ready), 64'd0);
    chk("midrst w_addr", 64'(w_addr), 64'd0);
    chk("midrst score", {24'd0, result_score}, 64'd0);
    chk("midrst label", 64'(result_label), 64'd0);
    @(negedge PCLK); PRESETn = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(posedge PCLK); #1; if (done || busy) seen = 1'b1; end
    chk("midrst no done", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
